// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, the burst header tag and the default busy timeout.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StLoad,
      StWaitBusy,
      StWaitDone,
      StHold
   } arb_state_e;

   localparam logic [7:0]  HDR_TAG     = 8'hA0;
   localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request after ptr_i,
// wrapping modulo NREQ, plus a flag telling whether any request is asserted.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [IDW-1:0] cand;

   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IDW'((32'(ptr_i) + k) % NREQ);
         if (!any_o && req_i[cand]) begin
            idx_o = cand;
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter feeding one UART transmitter, one byte per TX_START.
// Define UART_ARB_HDR_EN to prefix every burst with the header byte HDR_TAG | GRANT_ID.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ_VALID,
   input  logic [8*NREQ-1:0] REQ_DATA,
   input  logic [NREQ-1:0]   REQ_LAST,
   output logic [NREQ-1:0]   REQ_ACK,
   output logic [7:0]        TX_DATA,
   output logic              TX_START,
   input  logic              TX_BUSY,
   output logic              GRANT_VALID,
   output logic [IDW-1:0]    GRANT_ID,
   output logic              ERR_TIMEOUT
);

   localparam int unsigned    TW   = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

   arb_state_e      state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  gid_q, gid_d;
   logic            gvalid_q, gvalid_d;
   logic            last_q, last_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_start_q, tx_start_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            err_q, err_d;
`ifdef UART_ARB_HDR_EN
   logic            hdr_q, hdr_d;
`endif

   logic [7:0]      req_byte [NREQ];
   logic [IDW-1:0]  pick_idx;
   logic            pick_any;
   logic            cur_valid;
   logic            byte_done;
   logic            is_hdr;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req_i (REQ_VALID),
      .ptr_i (ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_byte[i] = REQ_DATA[8*i +: 8];
      end
   end

   assign cur_valid = REQ_VALID[gid_q];
`ifdef UART_ARB_HDR_EN
   assign is_hdr = hdr_q;
`else
   assign is_hdr = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gid_d      = gid_q;
      gvalid_d   = gvalid_q;
      last_d     = last_q;
      timer_d    = timer_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      ack_d      = '0;
      err_d      = 1'b0;
      byte_done  = 1'b0;
`ifdef UART_ARB_HDR_EN
      hdr_d      = hdr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               gid_d    = pick_idx;
               gvalid_d = 1'b1;
`ifdef UART_ARB_HDR_EN
               state_d  = StHdr;
`else
               state_d  = StLoad;
`endif
            end
         end
`ifdef UART_ARB_HDR_EN
         StHdr: begin
            tx_data_d  = HDR_TAG | 8'(gid_q);
            tx_start_d = 1'b1;
            timer_d    = '0;
            hdr_d      = 1'b1;
            state_d    = StWaitBusy;
         end
`endif
         StLoad: begin
            // Requester withdrew its byte before the ack: keep the grant and wait.
            if (cur_valid) begin
               tx_data_d    = req_byte[gid_q];
               tx_start_d   = 1'b1;
               ack_d[gid_q] = 1'b1;
               last_d       = REQ_LAST[gid_q];
               timer_d      = '0;
`ifdef UART_ARB_HDR_EN
               hdr_d        = 1'b0;
`endif
               state_d      = StWaitBusy;
            end else begin
               state_d = StHold;
            end
         end
         StWaitBusy: begin
            if (TX_BUSY) begin
               state_d = StWaitDone;
            end else if (timer_q == TMAX) begin
               err_d     = 1'b1;
               byte_done = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StWaitDone: begin
            if (!TX_BUSY) begin
               byte_done = 1'b1;
            end
         end
         StHold: begin
            if (cur_valid) begin
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase

      if (byte_done) begin
         if (last_q && !is_hdr) begin
            ptr_d    = gid_q;
            gvalid_d = 1'b0;
            state_d  = StIdle;
         end else begin
            state_d = cur_valid ? StLoad : StHold;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         ptr_q      <= IDW'(NREQ - 1);
         gid_q      <= '0;
         gvalid_q   <= 1'b0;
         last_q     <= 1'b0;
         timer_q    <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         ack_q      <= '0;
         err_q      <= 1'b0;
`ifdef UART_ARB_HDR_EN
         hdr_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gid_q      <= gid_d;
         gvalid_q   <= gvalid_d;
         last_q     <= last_d;
         timer_q    <= timer_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
`ifdef UART_ARB_HDR_EN
         hdr_q      <= hdr_d;
`endif
      end
   end

   assign REQ_ACK     = ack_q;
   assign TX_DATA     = tx_data_q;
   assign TX_START    = tx_start_q;
   assign GRANT_VALID = gvalid_q;
   assign GRANT_ID    = gid_q;
   assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with queued requesters and a busy model.
// Expected streams include header bytes when UART_ARB_HDR_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned IDW     = 2;
   localparam int unsigned TIMEOUT = 16;
`ifdef UART_ARB_HDR_EN
   localparam bit HDR_ON = 1'b1;
`else
   localparam bit HDR_ON = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic [NREQ-1:0]   REQ_VALID;
   logic [8*NREQ-1:0] REQ_DATA;
   logic [NREQ-1:0]   REQ_LAST;
   logic [NREQ-1:0]   REQ_ACK;
   logic [7:0]        TX_DATA;
   logic              TX_START;
   logic              TX_BUSY;
   logic              GRANT_VALID;
   logic [IDW-1:0]    GRANT_ID;
   logic              ERR_TIMEOUT;

   uart_tx_arbiter #(
      .NREQ    (NREQ),
      .IDW     (IDW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .REQ_VALID   (REQ_VALID),
      .REQ_DATA    (REQ_DATA),
      .REQ_LAST    (REQ_LAST),
      .REQ_ACK     (REQ_ACK),
      .TX_DATA     (TX_DATA),
      .TX_START    (TX_START),
      .TX_BUSY     (TX_BUSY),
      .GRANT_VALID (GRANT_VALID),
      .GRANT_ID    (GRANT_ID),
      .ERR_TIMEOUT (ERR_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk;
   int n_fail;

   // Requesters: per-index byte queues {last, data}; head advances on each ack.
   logic [8:0]  mem [NREQ][8];
   int unsigned cnt [NREQ];
   int unsigned head [NREQ];

   always @(negedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NREQ; i++) head[i] <= 0;
      end else begin
         for (int i = 0; i < NREQ; i++) if (REQ_ACK[i]) head[i] <= head[i] + 1;
      end
   end

   always_comb begin
      REQ_VALID = '0;
      REQ_DATA  = '0;
      REQ_LAST  = '0;
      for (int i = 0; i < NREQ; i++) begin
         REQ_VALID[i]      = head[i] < cnt[i];
         REQ_DATA[8*i +: 8] = mem[i][head[i][2:0]][7:0];
         REQ_LAST[i]       = mem[i][head[i][2:0]][8];
      end
   end

   // Transmitter: busy rises one cycle after TX_START and stays high 10 cycles.
   bit          busy_en;
   logic        arm;
   int unsigned bcnt;
   always @(negedge CLK or negedge RST) begin
      if (!RST) begin
         arm  <= 1'b0;
         bcnt <= 0;
      end else begin
         arm <= TX_START & busy_en;
         if (arm) bcnt <= 10;
         else if (bcnt != 0) bcnt <= bcnt - 1;
      end
   end
   assign TX_BUSY = (bcnt != 0);

   typedef struct {
      logic [7:0]      data;
      logic [IDW-1:0]  gid;
      logic [NREQ-1:0] ack;
      int unsigned     cyc;
   } ev_t;
   ev_t         log_ev [$];
   ev_t         mon_e;
   int unsigned err_log [$];

   always @(negedge CLK) begin
      if (TX_START === 1'b1) begin
         mon_e.data = TX_DATA;
         mon_e.gid  = GRANT_ID;
         mon_e.ack  = REQ_ACK;
         mon_e.cyc  = cyc;
         log_ev.push_back(mon_e);
      end
      if (ERR_TIMEOUT === 1'b1) err_log.push_back(cyc);
   end

   logic [7:0]      exp_d [$];
   logic [IDW-1:0]  exp_g [$];
   logic [NREQ-1:0] exp_a [$];

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   task automatic exp_clear();
      exp_d.delete();
      exp_g.delete();
      exp_a.delete();
   endtask

   task automatic exp_hdr(input logic [IDW-1:0] g);
      if (HDR_ON) begin
         exp_d.push_back(8'hA0 | {6'b0, g});
         exp_g.push_back(g);
         exp_a.push_back('0);
      end
   endtask

   task automatic exp_byte(input logic [7:0] d, input logic [IDW-1:0] g);
      logic [NREQ-1:0] a;
      a    = '0;
      a[g] = 1'b1;
      exp_d.push_back(d);
      exp_g.push_back(g);
      exp_a.push_back(a);
   endtask

   task automatic wait_log(input int unsigned n, input int unsigned budget, output bit ok);
      int unsigned k;
      k = 0;
      while (log_ev.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      ok = (log_ev.size() >= n);
   endtask

   task automatic do_reset();
      RST     = 1'b0;
      busy_en = 1'b1;
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      tick(2);
      RST = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      RST = 1'b0;
      #1;
      n_chk++; if (TX_START !== 1'b0) begin n_fail++; $display("FAIL reset TX_START: got %b, required 0", TX_START); end
      n_chk++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset TX_DATA: got %h, required 00", TX_DATA); end
      n_chk++; if (REQ_ACK !== 4'h0) begin n_fail++; $display("FAIL reset REQ_ACK: got %b, required 0000", REQ_ACK); end
      n_chk++; if (GRANT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset GRANT_VALID: got %b, required 0", GRANT_VALID); end
      n_chk++; if (GRANT_ID !== 2'd0) begin n_fail++; $display("FAIL reset GRANT_ID: got %0d, required 0", GRANT_ID); end
      n_chk++; if (ERR_TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL reset ERR_TIMEOUT: got %b, required 0", ERR_TIMEOUT); end
   endtask

   task automatic test_single();
      int unsigned base, v, k, s_last, gdrop;
      bit ok;
      do_reset();
      exp_clear();
      base      = log_ev.size();
      mem[0][0] = {1'b1, 8'h55};
      cnt[0]    = 1;
      v         = cyc;
      exp_hdr(0);
      exp_byte(8'h55, 0);
      wait_log(base + exp_d.size(), 100, ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single starts: got %0d, required %0d", log_ev.size() - base, exp_d.size()); end
      if (ok) begin
         n_chk++;
         if (log_ev[base].cyc !== v + 2) begin
            n_fail++; $display("FAIL single latency: got cycle %0d, required %0d", log_ev[base].cyc, v + 2);
         end
         for (int i = 0; i < exp_d.size(); i++) begin
            n_chk++;
            if (log_ev[base+i].data !== exp_d[i] || log_ev[base+i].gid !== exp_g[i] || log_ev[base+i].ack !== exp_a[i]) begin
               n_fail++;
               $display("FAIL single byte %0d: got data=%h gid=%0d ack=%b, required data=%h gid=%0d ack=%b", i,
                        log_ev[base+i].data, log_ev[base+i].gid, log_ev[base+i].ack, exp_d[i], exp_g[i], exp_a[i]);
            end
         end
         s_last = log_ev[base + exp_d.size() - 1].cyc;
         k = 0;
         while (GRANT_VALID !== 1'b0 && k < 100) begin tick(1); k++; end
         gdrop = cyc;
         n_chk++;
         if (gdrop !== s_last + 12) begin
            n_fail++; $display("FAIL single grant drop: got cycle %0d, required %0d", gdrop, s_last + 12);
         end
         n_chk++;
         if (TX_DATA !== 8'h55) begin n_fail++; $display("FAIL single TX_DATA hold: got %h, required 55", TX_DATA); end
      end
   endtask

   task automatic test_burst();
      int unsigned base;
      bit ok;
      do_reset();
      exp_clear();
      base      = log_ev.size();
      mem[1][0] = {1'b0, 8'h01};
      mem[1][1] = {1'b0, 8'h02};
      mem[1][2] = {1'b1, 8'h03};
      mem[2][0] = {1'b1, 8'h22};
      cnt[1]    = 3;
      cnt[2]    = 1;
      exp_hdr(1); exp_byte(8'h01, 1); exp_byte(8'h02, 1); exp_byte(8'h03, 1);
      exp_hdr(2); exp_byte(8'h22, 2);
      wait_log(base + exp_d.size(), 400, ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst starts: got %0d, required %0d", log_ev.size() - base, exp_d.size()); end
      if (ok) begin
         for (int i = 0; i < exp_d.size(); i++) begin
            n_chk++;
            if (log_ev[base+i].data !== exp_d[i] || log_ev[base+i].gid !== exp_g[i] || log_ev[base+i].ack !== exp_a[i]) begin
               n_fail++;
               $display("FAIL burst byte %0d: got data=%h gid=%0d ack=%b, required data=%h gid=%0d ack=%b", i,
                        log_ev[base+i].data, log_ev[base+i].gid, log_ev[base+i].ack, exp_d[i], exp_g[i], exp_a[i]);
            end
         end
      end
   endtask

   task automatic test_rr();
      int unsigned base;
      bit ok;
      do_reset();
      exp_clear();
      base      = log_ev.size();
      mem[0][0] = {1'b1, 8'h10};
      mem[0][1] = {1'b1, 8'h50};
      mem[1][0] = {1'b1, 8'h11};
      mem[2][0] = {1'b1, 8'h12};
      mem[3][0] = {1'b1, 8'h13};
      cnt[0] = 2; cnt[1] = 1; cnt[2] = 1; cnt[3] = 1;
      exp_hdr(0); exp_byte(8'h10, 0);
      exp_hdr(1); exp_byte(8'h11, 1);
      exp_hdr(2); exp_byte(8'h12, 2);
      exp_hdr(3); exp_byte(8'h13, 3);
      exp_hdr(0); exp_byte(8'h50, 0);
      wait_log(base + exp_d.size(), 600, ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr starts: got %0d, required %0d", log_ev.size() - base, exp_d.size()); end
      if (ok) begin
         for (int i = 0; i < exp_d.size(); i++) begin
            n_chk++;
            if (log_ev[base+i].data !== exp_d[i] || log_ev[base+i].gid !== exp_g[i] || log_ev[base+i].ack !== exp_a[i]) begin
               n_fail++;
               $display("FAIL rr byte %0d: got data=%h gid=%0d ack=%b, required data=%h gid=%0d ack=%b", i,
                        log_ev[base+i].data, log_ev[base+i].gid, log_ev[base+i].ack, exp_d[i], exp_g[i], exp_a[i]);
            end
         end
      end
   endtask

   task automatic test_hold();
      int unsigned base, n0;
      bit ok;
      do_reset();
      exp_clear();
      base      = log_ev.size();
      mem[3][0] = {1'b0, 8'h33};
      cnt[3]    = 1;
      exp_hdr(3); exp_byte(8'h33, 3);
      wait_log(base + exp_d.size(), 100, ok);
      mem[0][0] = {1'b1, 8'h0F};
      cnt[0]    = 1;
      n0        = log_ev.size();
      tick(20);
      n_chk++; if (log_ev.size() !== n0) begin n_fail++; $display("FAIL hold gap starts: got %0d, required %0d", log_ev.size(), n0); end
      n_chk++; if (GRANT_ID !== 2'd3 || GRANT_VALID !== 1'b1) begin
         n_fail++; $display("FAIL hold grant: got valid=%b id=%0d, required valid=1 id=3", GRANT_VALID, GRANT_ID);
      end
      mem[3][1] = {1'b1, 8'hAA};
      cnt[3]    = 2;
      exp_byte(8'hAA, 3);
      exp_hdr(0); exp_byte(8'h0F, 0);
      wait_log(base + exp_d.size(), 300, ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL hold starts: got %0d, required %0d", log_ev.size() - base, exp_d.size()); end
      if (ok) begin
         for (int i = 0; i < exp_d.size(); i++) begin
            n_chk++;
            if (log_ev[base+i].data !== exp_d[i] || log_ev[base+i].gid !== exp_g[i] || log_ev[base+i].ack !== exp_a[i]) begin
               n_fail++;
               $display("FAIL hold byte %0d: got data=%h gid=%0d ack=%b, required data=%h gid=%0d ack=%b", i,
                        log_ev[base+i].data, log_ev[base+i].gid, log_ev[base+i].ack, exp_d[i], exp_g[i], exp_a[i]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int unsigned base, eb, k;
      bit ok;
      do_reset();
      busy_en = 1'b0;
      exp_clear();
      base      = log_ev.size();
      eb        = err_log.size();
      mem[2][0] = {1'b0, 8'hC1};
      mem[2][1] = {1'b1, 8'hC2};
      cnt[2]    = 2;
      exp_hdr(2); exp_byte(8'hC1, 2); exp_byte(8'hC2, 2);
      wait_log(base + exp_d.size(), 300, ok);
      k = 0;
      while (err_log.size() < eb + exp_d.size() && k < 60) begin tick(1); k++; end
      n_chk++; if (ok !== 1'b1 || err_log.size() !== eb + exp_d.size()) begin
         n_fail++; $display("FAIL timeout counts: got starts=%0d errs=%0d, required %0d each",
                            log_ev.size() - base, err_log.size() - eb, exp_d.size());
      end
      if (ok && err_log.size() >= eb + exp_d.size()) begin
         for (int i = 0; i < exp_d.size(); i++) begin
            n_chk++;
            if (log_ev[base+i].data !== exp_d[i] || err_log[eb+i] !== log_ev[base+i].cyc + TIMEOUT) begin
               n_fail++;
               $display("FAIL timeout byte %0d: got data=%h err cycle=%0d, required data=%h err cycle=%0d", i,
                        log_ev[base+i].data, err_log[eb+i], exp_d[i], log_ev[base+i].cyc + TIMEOUT);
            end
            if (i + 1 < exp_d.size()) begin
               n_chk++;
               if (log_ev[base+i+1].cyc !== err_log[eb+i] + 1) begin
                  n_fail++; $display("FAIL timeout continue %0d: got start cycle %0d, required %0d", i,
                                     log_ev[base+i+1].cyc, err_log[eb+i] + 1);
               end
            end
         end
      end
      busy_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int unsigned base;
      bit ok;
      do_reset();
      exp_clear();
      base      = log_ev.size();
      mem[1][0] = {1'b0, 8'h77};
      mem[1][1] = {1'b1, 8'h78};
      cnt[1]    = 2;
      wait_log(base + (HDR_ON ? 2 : 1), 100, ok);
      tick(5);
      RST = 1'b0;
      #1;
      n_chk++; if (TX_START !== 1'b0 || ERR_TIMEOUT !== 1'b0) begin
         n_fail++; $display("FAIL midreset strobes: got start=%b err=%b, required 0 0", TX_START, ERR_TIMEOUT);
      end
      n_chk++; if (TX_DATA !== 8'h00) begin n_fail++; $display("FAIL midreset TX_DATA: got %h, required 00", TX_DATA); end
      n_chk++; if (REQ_ACK !== 4'h0) begin n_fail++; $display("FAIL midreset REQ_ACK: got %b, required 0000", REQ_ACK); end
      n_chk++; if (GRANT_VALID !== 1'b0 || GRANT_ID !== 2'd0) begin
         n_fail++; $display("FAIL midreset grant: got valid=%b id=%0d, required 0 0", GRANT_VALID, GRANT_ID);
      end
      cnt[1]    = 0;
      mem[0][0] = {1'b1, 8'h5A};
      mem[2][0] = {1'b1, 8'h6B};
      cnt[0]    = 1;
      cnt[2]    = 1;
      base      = log_ev.size();
      tick(1);
      RST = 1'b1;
      exp_hdr(0); exp_byte(8'h5A, 0);
      exp_hdr(2); exp_byte(8'h6B, 2);
      wait_log(base + exp_d.size(), 300, ok);
      n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midreset starts: got %0d, required %0d", log_ev.size() - base, exp_d.size()); end
      if (ok) begin
         for (int i = 0; i < exp_d.size(); i++) begin
            n_chk++;
            if (log_ev[base+i].data !== exp_d[i] || log_ev[base+i].gid !== exp_g[i] || log_ev[base+i].ack !== exp_a[i]) begin
               n_fail++;
               $display("FAIL midreset byte %0d: got data=%h gid=%0d ack=%b, required data=%h gid=%0d ack=%b", i,
                        log_ev[base+i].data, log_ev[base+i].gid, log_ev[base+i].ack, exp_d[i], exp_g[i], exp_a[i]);
            end
         end
      end
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      busy_en = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         cnt[i] = 0;
         for (int j = 0; j < 8; j++) mem[i][j] = '0;
      end
      test_reset();
      test_single();
      test_burst();
      test_rr();
      test_hold();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1);
   end

endmodule
